// File: rtl/mem_io_uart_tx.sv
// Memory-mapped 8N1 serial transmitter with a byte FIFO on the processor data bus.
// Latency: register reads are combinational; the first tx fall is 1 clk after a push from idle.
// Backpressure: a push into a full FIFO is dropped and sets the sticky OVF flag (unless a pop frees the slot on that edge).
module mem_io_uart_tx #(
  parameter logic [7:0]  BASE_ADDR  = 8'hF0,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_wr,
  input  logic [7:0]  mem_addr,
  input  logic [31:0] mem_data_out,
  output logic        hit,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        irq
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_nxt;
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [4:0]  count;
  logic        ovf, en, ie;
  logic [15:0] baud;
  logic [15:0] timer, timer_nxt;
  logic [7:0]  shift, shift_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        tx_nxt;
  logic        pop;
  logic        full, empty, busy, bit_end;
  logic        wr_hit, push_req, push_ok;
  logic [1:0]  offset;
  logic        unused_bits;

  assign hit      = (mem_addr[7:2] == BASE_ADDR[7:2]);
  assign offset   = mem_addr[1:0];
  assign wr_hit   = mem_wr && hit;
  assign full     = (count == 5'(FIFO_DEPTH));
  assign empty    = (count == 5'd0);
  assign busy     = (state != IDLE);
  assign bit_end  = (timer == 16'd0);
  assign push_req = wr_hit && (offset == 2'd0);
  // A pop on the same edge frees the head slot, so a push into a full FIFO still lands.
  assign push_ok  = push_req && (!full || pop);
  assign unused_bits = ^mem_data_out[31:16];

  // Zero-latency register read mux; reflects state before the current edge.
  always_comb begin
    rd_data = 32'd0;
    if (hit) begin
      case (offset)
        2'd1:    rd_data = {23'd0, count, ovf, busy, empty, full};
        2'd2:    rd_data = {16'd0, baud};
        2'd3:    rd_data = {30'd0, ie, en};
        default: rd_data = 32'd0;
      endcase
    end
  end

  // Frame sequencer: next state, bit timer, shifter and the registered tx value.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    tx_nxt      = tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (en && !empty) begin
          pop       = 1'b1;
          state_nxt = START;
          shift_nxt = fifo_mem[rd_ptr];
          timer_nxt = baud;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt   = DATA;
          timer_nxt   = baud;
          bit_cnt_nxt = 3'd0;
          tx_nxt      = shift[0];
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_nxt = baud;
          if (bit_cnt == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Chain straight into the next start bit so there is no idle gap.
          if (en && !empty) begin
            pop       = 1'b1;
            state_nxt = START;
            shift_nxt = fifo_mem[rd_ptr];
            timer_nxt = baud;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          timer_nxt = timer - 16'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequencer state register; reset forces the line idle and drops any frame in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      timer   <= 16'd0;
      shift   <= 8'd0;
      bit_cnt <= 3'd0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      tx      <= tx_nxt;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= mem_data_out[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 5'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Control registers, sticky overflow flag and the interrupt line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud <= DIV_RESET;
      en   <= 1'b0;
      ie   <= 1'b0;
      ovf  <= 1'b0;
      irq  <= 1'b0;
    end else begin
      irq <= empty && (state == IDLE) && ie;
      if (push_req && full && !pop) begin
        ovf <= 1'b1;
      end else if (wr_hit && (offset == 2'd1) && mem_data_out[3]) begin
        ovf <= 1'b0;
      end
      if (wr_hit && (offset == 2'd2)) baud <= mem_data_out[15:0];
      if (wr_hit && (offset == 2'd3)) {ie, en} <= mem_data_out[1:0];
    end
  end

endmodule
